// File: rtl/column_readout_scheduler.sv
// First-level readout scheduler: drains N_COL column FIFOs one word at a time,
// round-robin, onto a registered valid/ready output and counts transferred words.
`timescale 1ns/1ps
module column_readout_scheduler #(
  parameter int N_COL = 4,
  parameter int DW    = 28,
  parameter int SW    = 2
) (
  input  logic                clk_40MHz,
  input  logic                rst_n,
  input  logic                readout_start,
  input  logic [N_COL-1:0]    fifo_empty,
  input  logic [N_COL*DW-1:0] fifo_data,
  output logic [N_COL-1:0]    fifo_rd_en,
  output logic [DW-1:0]       out_data,
  output logic [SW-1:0]       out_src,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                readout_busy,
  output logic                readout_done,
  output logic [15:0]         word_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_RD   = 3'd2,
    ST_LOAD = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [SW-1:0]     ptr_r, ptr_s;
  logic [SW-1:0]     grant_r, grant_s;
  logic [SW-1:0]     pick_s, cand_s;
  logic              found_s;
  logic              all_empty_s;
  logic              handshake_s;
  logic [DW-1:0]     sel_data_s;
  logic [N_COL-1:0]  rd_en_r, rd_en_s;
  logic [DW-1:0]     data_r, data_s;
  logic [SW-1:0]     src_r, src_s;
  logic              valid_r, valid_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [15:0]       count_r, count_s;

  assign all_empty_s  = &fifo_empty;
  assign handshake_s  = valid_r & out_ready;

  assign fifo_rd_en   = rd_en_r;
  assign out_data     = data_r;
  assign out_src      = src_r;
  assign out_valid    = valid_r;
  assign readout_busy = busy_r;
  assign readout_done = done_r;
  assign word_count   = count_r;

  // Round-robin search: first non-empty column starting at ptr, wrapping mod N_COL.
  always_comb begin
    found_s = 1'b0;
    pick_s  = ptr_r;
    cand_s  = ptr_r;
    for (int i = 0; i < N_COL; i++) begin
      cand_s  = ptr_r + SW'(i);
      pick_s  = (!found_s && !fifo_empty[cand_s]) ? cand_s : pick_s;
      found_s = found_s | ~fifo_empty[cand_s];
    end
  end

  // Select the granted column's read data.
  always_comb begin
    sel_data_s = {DW{1'b0}};
    for (int c = 0; c < N_COL; c++) begin
      sel_data_s = (grant_r == SW'(c)) ? fifo_data[c*DW +: DW] : sel_data_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: state_s = readout_start ? ST_ARB : ST_IDLE;
      ST_ARB:  state_s = all_empty_s ? ST_IDLE : ST_RD;
      ST_RD:   state_s = ST_LOAD;
      ST_LOAD: state_s = ST_HOLD;
      ST_HOLD: state_s = handshake_s ? ST_ARB : ST_HOLD;
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered datapath and outputs.
  always_comb begin
    ptr_s   = ptr_r;
    grant_s = grant_r;
    rd_en_s = {N_COL{1'b0}};
    data_s  = data_r;
    src_s   = src_r;
    valid_s = valid_r;
    done_s  = 1'b0;
    count_s = count_r;
    busy_s  = (state_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (readout_start) begin
          count_s = 16'h0000;
          ptr_s   = {SW{1'b0}};
        end else begin
          count_s = count_r;
        end
      end
      ST_ARB: begin
        if (all_empty_s) begin
          done_s = 1'b1;
        end else begin
          grant_s = pick_s;
          rd_en_s = {{(N_COL-1){1'b0}}, 1'b1} << pick_s;
        end
      end
      ST_RD: begin
        rd_en_s = {N_COL{1'b0}};
      end
      ST_LOAD: begin
        data_s  = sel_data_s;
        src_s   = grant_r;
        valid_s = 1'b1;
      end
      ST_HOLD: begin
        if (handshake_s) begin
          valid_s = 1'b0;
          count_s = (count_r == 16'hFFFF) ? count_r : count_r + 16'd1;
          ptr_s   = grant_r + SW'(1);
        end else begin
          valid_s = valid_r;
        end
      end
      default: begin
        ptr_s   = {SW{1'b0}};
        grant_s = {SW{1'b0}};
        data_s  = {DW{1'b0}};
        src_s   = {SW{1'b0}};
        valid_s = 1'b0;
        count_s = 16'h0000;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= {SW{1'b0}};
      grant_r <= {SW{1'b0}};
      rd_en_r <= {N_COL{1'b0}};
      data_r  <= {DW{1'b0}};
      src_r   <= {SW{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      count_r <= 16'h0000;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      grant_r <= grant_s;
      rd_en_r <= rd_en_s;
      data_r  <= data_s;
      src_r   <= src_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      count_r <= count_s;
    end
  end

endmodule
